// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out bit distributor.
// Holds the default word width, the bit-order encoding and the start-slot rule.
package sipo_pkg;

    localparam int unsigned W_DEFAULT  = 8;
    localparam int unsigned SW_DEFAULT = $clog2(W_DEFAULT);

    typedef enum logic {
        MsbFirst = 1'b0,
        LsbFirst = 1'b1
    } bit_order_e;

    // Slot that receives the first bit of every word.
    function automatic int unsigned start_idx(int unsigned w, bit lsb_first);
        return lsb_first ? 0 : w - 1;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder.
// Turns the slot index into per-slot write enables.
module decoder_onehot #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/eight_way_demux_sipo.sv
// Serial-in/parallel-out bit distributor with a one-entry valid/ready output register.
// Each accepted bit lands in slot idx; every W-th bit commits the assembled word.
module eight_way_demux_sipo
    import sipo_pkg::*;
#(
    parameter int unsigned W         = W_DEFAULT,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned SW       = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          sin_valid,
    input  logic          sin_data,
    output logic          sin_ready,
    output logic          pout_valid,
    output logic [W-1:0]  pout_data,
    input  logic          pout_ready,
    output logic [SW-1:0] fill_cnt
);

    localparam bit_order_e  Order    = bit_order_e'(LSB_FIRST);
    localparam logic [SW-1:0] IdxStart = SW'(start_idx(W, LSB_FIRST));
    localparam logic [SW-1:0] FillLast = SW'(W - 1);

    logic [SW-1:0] idx_q;
    logic [SW-1:0] fill_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [W-1:0]  wen;
    logic          valid_q;
    logic [W-1:0]  data_q;
    logic          last;
    logic          accept;
    logic          commit;

    decoder_onehot #(
        .N  (W),
        .SW (SW)
    ) u_dec (
        .sel    (idx_q),
        .onehot (wen)
    );

    // The last bit may only enter when the output register is free or emptying this cycle;
    // this makes sin_ready combinationally dependent on pout_ready.
    assign last      = (fill_q == FillLast);
    assign sin_ready = !clr && (!last || !valid_q || pout_ready);
    assign accept    = sin_valid && sin_ready;
    assign commit    = accept && last;
    assign acc_d     = (acc_q & ~wen) | (wen & {W{sin_data}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= IdxStart;
            fill_q  <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (clr) begin
                idx_q  <= IdxStart;
                fill_q <= '0;
            end else if (accept) begin
                acc_q  <= acc_d;
                idx_q  <= (Order == LsbFirst) ? idx_q + SW'(1) : idx_q - SW'(1);
                fill_q <= fill_q + SW'(1);
            end
            if (commit) begin
                data_q  <= acc_d;
                valid_q <= 1'b1;
            end else if (valid_q && pout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pout_valid = valid_q;
    assign pout_data  = data_q;
    assign fill_cnt   = fill_q;

endmodule

// File: tb/tb_eight_way_demux_sipo.sv
// Directed bench for eight_way_demux_sipo: one LSB-first and one MSB-first instance.
// Word table with hand-computed results plus sequences for stall, clr and reset.
module tb_eight_way_demux_sipo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       sin_data = 1'b0;
    logic       pout_ready = 1'b1;
    logic       a_sin_valid = 1'b0;
    logic       b_sin_valid = 1'b0;
    logic       a_sin_ready, b_sin_ready;
    logic       a_pout_valid, b_pout_valid;
    logic [7:0] a_pout_data, b_pout_data;
    logic [2:0] a_fill, b_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eight_way_demux_sipo #(.W(8), .LSB_FIRST(1'b1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .sin_valid  (a_sin_valid),
        .sin_data   (sin_data),
        .sin_ready  (a_sin_ready),
        .pout_valid (a_pout_valid),
        .pout_data  (a_pout_data),
        .pout_ready (pout_ready),
        .fill_cnt   (a_fill)
    );

    eight_way_demux_sipo #(.W(8), .LSB_FIRST(1'b0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .sin_valid  (b_sin_valid),
        .sin_data   (sin_data),
        .sin_ready  (b_sin_ready),
        .pout_valid (b_pout_valid),
        .pout_data  (b_pout_data),
        .pout_ready (pout_ready),
        .fill_cnt   (b_fill)
    );

    // seq[0] is the first bit on the wire
    typedef struct {
        logic       msb;
        logic [0:7] seq;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:7] s;

        vecs[0] = '{msb: 1'b0, seq: 8'b10110010, exp_word: 8'h4D};
        vecs[1] = '{msb: 1'b0, seq: 8'b10100101, exp_word: 8'hA5};
        vecs[2] = '{msb: 1'b0, seq: 8'b00111100, exp_word: 8'h3C};
        vecs[3] = '{msb: 1'b1, seq: 8'b10000001, exp_word: 8'h81};
        vecs[4] = '{msb: 1'b1, seq: 8'b11000000, exp_word: 8'hC0};

        // Reset values while held in reset
        tick();
        tick();
        chk("rst_valid", {7'd0, a_pout_valid}, 8'd0);
        chk("rst_data", a_pout_data, 8'h00);
        chk("rst_fill", {5'd0, a_fill}, 8'd0);
        chk("rst_ready", {7'd0, a_sin_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: words streamed back to back with pout_ready high
        pout_ready = 1'b1;
        foreach (vecs[v]) begin
            for (int i = 0; i < 8; i++) begin
                a_sin_valid = !vecs[v].msb;
                b_sin_valid = vecs[v].msb;
                sin_data    = vecs[v].seq[i];
                #1;
                chk($sformatf("v%0d_fill%0d", v, i),
                    {5'd0, vecs[v].msb ? b_fill : a_fill}, 8'(i));
                chk($sformatf("v%0d_ready%0d", v, i),
                    {7'd0, vecs[v].msb ? b_sin_ready : a_sin_ready}, 8'd1);
                if (i == 7)
                    chk($sformatf("v%0d_early_valid", v),
                        {7'd0, vecs[v].msb ? b_pout_valid : a_pout_valid}, 8'd0);
                tick();
            end
            chk($sformatf("v%0d_valid", v),
                {7'd0, vecs[v].msb ? b_pout_valid : a_pout_valid}, 8'd1);
            chk($sformatf("v%0d_word", v),
                vecs[v].msb ? b_pout_data : a_pout_data, vecs[v].exp_word);
        end
        a_sin_valid = 1'b0;
        b_sin_valid = 1'b0;
        tick();
        chk("drain_a", {7'd0, a_pout_valid}, 8'd0);
        chk("drain_b", {7'd0, b_pout_valid}, 8'd0);

        // Backpressure: hold 0xA5, stall the 8th bit of 0x3C
        pout_ready = 1'b0;
        s = 8'b10100101;
        for (int i = 0; i < 8; i++) begin
            a_sin_valid = 1'b1;
            sin_data    = s[i];
            tick();
        end
        chk("bp_valid", {7'd0, a_pout_valid}, 8'd1);
        chk("bp_word", a_pout_data, 8'hA5);
        s = 8'b00111100;
        for (int i = 0; i < 7; i++) begin
            sin_data = s[i];
            #1;
            chk($sformatf("bp_ready%0d", i), {7'd0, a_sin_ready}, 8'd1);
            tick();
        end
        sin_data = s[7];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall_ready%0d", i), {7'd0, a_sin_ready}, 8'd0);
            chk($sformatf("bp_stall_fill%0d", i), {5'd0, a_fill}, 8'd7);
            chk($sformatf("bp_stall_word%0d", i), a_pout_data, 8'hA5);
            tick();
        end
        pout_ready = 1'b1;
        #1;
        chk("bp_release_ready", {7'd0, a_sin_ready}, 8'd1);
        tick();
        chk("bp_next_valid", {7'd0, a_pout_valid}, 8'd1);
        chk("bp_next_word", a_pout_data, 8'h3C);
        chk("bp_next_fill", {5'd0, a_fill}, 8'd0);
        a_sin_valid = 1'b0;
        tick();
        chk("bp_drained", {7'd0, a_pout_valid}, 8'd0);

        // clr after 5 bits, then 8 ones
        sin_data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_sin_valid = 1'b1;
            tick();
        end
        chk("clr_pre_fill", {5'd0, a_fill}, 8'd5);
        clr      = 1'b1;
        sin_data = 1'b1;
        #1;
        chk("clr_ready", {7'd0, a_sin_ready}, 8'd0);
        tick();
        clr = 1'b0;
        chk("clr_fill", {5'd0, a_fill}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) chk("clr_no_early_commit", {7'd0, a_pout_valid}, 8'd0);
        end
        chk("clr_valid", {7'd0, a_pout_valid}, 8'd1);
        chk("clr_word", a_pout_data, 8'hFF);

        // Async reset mid-handshake and mid-word
        pout_ready = 1'b0;
        sin_data   = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        a_sin_valid = 1'b0;
        chk("mid_fill", {5'd0, a_fill}, 8'd3);
        chk("mid_valid", {7'd0, a_pout_valid}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, a_pout_valid}, 8'd0);
        chk("arst_data", a_pout_data, 8'h00);
        chk("arst_fill", {5'd0, a_fill}, 8'd0);
        chk("arst_ready", {7'd0, a_sin_ready}, 8'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
